// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown display: FSM states, digit index
// and 7-segment patterns ordered {g,f,e,d,c,b,a}.
package countdown_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] digit_idx_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_EXPIRED = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/countdown_seg7_decode.sv
// Combinational BCD nibble to 7-segment decode; non-decimal nibbles show a dash.
module countdown_seg7_decode
    import countdown_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/countdown_display.sv
// Samples the slow BCD countdown into clk, scans a 4-digit display and raises an alarm at 00:00.
// Optional: COUNTDOWN_DISPLAY_BLANK_LEADING_ZERO_EN blanks a zero minute-tens digit.
//
// state      | meaning
// ST_IDLE    | no count loaded yet, or alarm finished; steady display
// ST_ARMED   | non-zero count running; colon on digit 2
// ST_EXPIRED | count hit 00:00; alarm high, display blinks
module countdown_display
    import countdown_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_DIV    = 250000,
    parameter int ALARM_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       alarm
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int ALARM_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_CYCLES - 1);

    logic [15:0]        s1_q, s1_d, s2_q, s2_d, stable_q, stable_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    digit_idx_t         idx_q, idx_d;
    state_t             state_q, state_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               dp_q, dp_d;
    logic               alarm_q, alarm_d;

    logic               enter_exp;
    logic [3:0]         nibble;
    logic [6:0]         seg_dec;

    // A multi-bit change is only accepted once two consecutive samples agree.
    always_comb begin
        s1_d     = {minute, second};
        s2_d     = s1_q;
        stable_d = (s1_q == s2_q) ? s2_q : stable_q;
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    // The FSM looks at the value stable is about to take, saving one cycle of latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (stable_d != '0) state_d = ST_ARMED;
            ST_ARMED:   if (stable_d == '0) state_d = ST_EXPIRED;
            ST_EXPIRED: begin
                if (stable_d != '0)
                    state_d = ST_ARMED;
                else if (alarm_cnt_q == ALARM_LAST)
                    state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
        enter_exp = (state_q != ST_EXPIRED) && (state_d == ST_EXPIRED);
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_on_q;
        if (enter_exp) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end

        alarm_cnt_d = alarm_cnt_q;
        if (enter_exp)
            alarm_cnt_d = '0;
        else if (state_q == ST_EXPIRED && alarm_cnt_q != ALARM_LAST)
            alarm_cnt_d = alarm_cnt_q + ALARM_W'(1);
    end

    always_comb begin
        case (idx_q)
            2'd0:    nibble = stable_q[3:0];
            2'd1:    nibble = stable_q[7:4];
            2'd2:    nibble = stable_q[11:8];
            default: nibble = stable_q[15:12];
        endcase
    end

    countdown_seg7_decode u_decode (
        .bcd (nibble),
        .seg (seg_dec)
    );

    always_comb begin
        seg_d = seg_dec;
`ifdef COUNTDOWN_DISPLAY_BLANK_LEADING_ZERO_EN
        if (idx_q == 2'd3 && nibble == 4'd0)
            seg_d = SEG_BLANK;
`endif
        an_d    = ~(4'b0001 << idx_q);
        dp_d    = (state_q == ST_ARMED) && (idx_q == 2'd2);
        alarm_d = (state_q == ST_EXPIRED);
        if (state_q == ST_EXPIRED && !blink_on_q) begin
            an_d  = 4'b1111;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            stable_q    <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            state_q     <= ST_IDLE;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            alarm_cnt_q <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1111;
            dp_q        <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            stable_q    <= stable_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            alarm_cnt_q <= alarm_cnt_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
            alarm_q     <= alarm_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign dp    = dp_q;
    assign alarm = alarm_q;

endmodule

// File: tb/tb_countdown_display.sv
// Randomized bench for countdown_display against a cycle-count based reference model.
module tb_countdown_display;

    localparam int SD = 4;
    localparam int BD = 6;
    localparam int AC = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] minute, second;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp, alarm;

    countdown_display #(.SCAN_DIV(SD), .BLINK_DIV(BD), .ALARM_CYCLES(AC)) dut (
        .clk    (clk),
        .rst    (rst),
        .minute (minute),
        .second (second),
        .seg    (seg),
        .an     (an),
        .dp     (dp),
        .alarm  (alarm)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int alarm_hi = 0;

    // reference model: edges since reset, last two inputs, accepted value, mode and expiry start
    int          n;
    int          e_start;
    int          mode;      // 0 idle, 1 armed, 2 expired
    logic [15:0] p1, p2, stab;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_dp, exp_alarm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic model_reset();
        n = 0; e_start = 0; mode = 0;
        p1 = '0; p2 = '0; stab = '0;
        exp_seg = 7'h00; exp_an = 4'hF; exp_dp = 1'b0; exp_alarm = 1'b0;
    endtask

    task automatic model_edge(input logic [15:0] v);
        int         idx;
        logic [3:0] nib;
        bit         on;
        idx = (n / SD) % 4;
        nib = stab[idx*4 +: 4];
        on  = (((n - e_start) / BD) % 2) == 0;
        exp_seg = seg_of(nib);
`ifdef COUNTDOWN_DISPLAY_BLANK_LEADING_ZERO_EN
        if (idx == 3 && nib == 4'd0) exp_seg = 7'h00;
`endif
        exp_an    = 4'(~(4'b0001 << idx));
        exp_dp    = (mode == 1) && (idx == 2);
        exp_alarm = (mode == 2);
        if (mode == 2 && !on) begin
            exp_an  = 4'hF;
            exp_seg = 7'h00;
        end
        n++;
        if (p1 == p2) stab = p2;
        p2 = p1;
        p1 = v;
        case (mode)
            0: if (stab != 0) mode = 1;
            1: if (stab == 0) begin mode = 2; e_start = n; end
            default: begin
                if (stab != 0) mode = 1;
                else if (n - e_start == AC) mode = 0;
            end
        endcase
    endtask

    // Called at a negedge: check, drive the next input, let one edge happen, return at next negedge.
    task automatic step(input logic [15:0] v);
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("an", 32'(an), 32'(exp_an));
        chk("dp", 32'(dp), 32'(exp_dp));
        chk("alarm", 32'(alarm), 32'(exp_alarm));
        if (alarm) alarm_hi++;
        {minute, second} = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
    endtask

    task automatic hold(input logic [15:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) step(v);
    endtask

    // Asynchronous reset asserted between edges; outputs must return immediately.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_alarm", 32'(alarm), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        minute = 8'h00;
        second = 8'h00;
        model_reset();
        @(negedge clk);
        do_reset();

        hold(16'h0000, 10 * SD);
        hold(16'h1234, 8 * SD);

        hold(16'h0001, 10);
        alarm_hi = 0;
        hold(16'h0000, AC + 4 * BD);
        chk("alarm_len", 32'(alarm_hi), 32'(AC));
        hold(16'h0000, 4 * SD);

        hold(16'h0001, 6);
        hold(16'h0000, 10);
        hold(16'h0500, 5 * SD);

        for (int i = 0; i < 30; i++) step((i % 2) ? 16'h5678 : 16'h1234);
        hold(16'h12A0, 5 * SD);

        hold(16'h0001, 6);
        hold(16'h0000, 8);
        do_reset();
        hold(16'h0000, 40);

        for (int k = 0; k < 150; k++) begin
            int          kind, len;
            logic [15:0] a, b;
            kind = $urandom_range(0, 6);
            len  = $urandom_range(1, 30);
            a    = 16'($urandom);
            b    = 16'($urandom);
            case (kind)
                0, 1: hold(16'h0000, len);
                2:    hold({4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))}, len);
                3:    hold(a, len);
                4:    hold(16'h0001, len);
                5:    for (int i = 0; i < len; i++) step(i[0] ? a : b);
                default: begin
                    if ($urandom_range(0, 3) == 0) do_reset();
                    else hold(16'h0000, len);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/countdown_display.md
# countdown_display

Downstream consumer of the BCD minute/second countdown clock. Samples its `minute`/`second` outputs, which come from a slow clock domain, into the fast system clock domain. Drives a 4-digit multiplexed 7-segment display and raises an expiry alarm when the count reaches 00:00. The display blinks while expired.

## Interface
- `SCAN_DIV`, default 1000: `clk` cycles per digit slot; must be ≥2.
- `BLINK_DIV`, default 250000: `clk` cycles per blink half-period; must be ≥2.
- `ALARM_CYCLES`, default 1000000: `clk` cycles `alarm` stays high after expiry; must be ≥1.
- `clk`  in  1  fast system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `minute`  in  8  BCD minutes {tens, ones} from countdown clock; asynchronous to `clk`.
- `second`  in  8  BCD seconds {tens, ones} from countdown clock; asynchronous to `clk`.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active high.
- `an`  out  4  digit enables, active low; at most one low.
- `dp`  out  1  decimal point, active high; used as the colon.
- `alarm`  out  1  expiry indication, active high.

## Operation
- Input capture:
  - Each cycle `s1 <= {minute,second}`, then `s2 <= s1`.
  - When `s1 == s2`, `stable <= s2`; otherwise `stable` holds.
  - A value settled before edge k appears in `stable` after edge k+2.
  - Glitching multi-bit transitions never reach `stable`.
- Digit scan:
  - `idx` (2 bits) selects digit 0 = second ones (`an[0]`), 1 = second tens, 2 = minute ones, 3 = minute tens.
  - `idx` advances mod 4 when the scan counter wraps at SCAN_DIV-1.
- Decode:
  - BCD 0–9 → standard 7-segment patterns.
  - Nibble A–F → segment g only (dash).
- FSM, evaluated on `stable`:
  - IDLE → ARMED when `stable != 0`.
  - ARMED → EXPIRED when `stable == 0`.
  - EXPIRED → ARMED when `stable != 0` (reload); reload wins over timeout if both happen in the same cycle.
  - EXPIRED → IDLE when the alarm counter reaches ALARM_CYCLES-1.
- Outputs per state:
  - IDLE: steady display, `dp` = 0, `alarm` = 0.
  - ARMED: steady display; `dp` = 1 while `idx` == 2.
  - EXPIRED: `alarm` = 1. When the blink phase is off, `an` = 4'b1111 and `seg` = 0. `dp` = 0.
- Blink:
  - Counter counts 0..BLINK_DIV-1; the phase toggles at wrap.
  - On entry to EXPIRED the counter is cleared and the phase is set to on.
- Alarm counter: cleared on entry to EXPIRED; increments each cycle while in EXPIRED.

## Timing
- Reset values:
  - `seg` = 0, `an` = 4'b1111, `dp` = 0, `alarm` = 0.
  - State IDLE, `idx` = 0, all counters 0, `s1`/`s2`/`stable` = 0, blink phase on.
- `seg`/`an`/`dp`/`alarm` are registered; they reflect `idx`/state/`stable` one cycle later.
- Latency from input settle to state change is 3 edges; to `alarm` rise is 4 edges.
- `alarm` is high for exactly ALARM_CYCLES cycles unless a reload ends EXPIRED early; then it falls one cycle after the state leaves EXPIRED.
- Reset at power-up with input 00:00 stays in IDLE: no alarm without a prior non-zero count.
- Reset mid-EXPIRED returns immediately to reset values. If the input is still 00:00, the block stays in IDLE.
- Changing `stable` mid-scan takes effect on the next registered output; no scan restart.

## Configuration
- `COUNTDOWN_DISPLAY_BLANK_LEADING_ZERO_EN` defined:
  - Digit 3 is blanked (`seg` = 0) when minute tens == 0.
  - Its `an` bit still scans, so the duty cycle is unchanged.
- Not defined: all four digits are always shown, including a leading 0.

## Structure
- Shared package `countdown_pkg`:
  - State enum {IDLE, ARMED, EXPIRED}.
  - Segment constants SEG_BLANK, SEG_DASH and digit patterns SEG_0..SEG_9.
  - 2-bit digit index type.
- Sub-module `countdown_seg7_decode`: combinational 4-bit BCD → 7-bit segments; instantiated once on the muxed nibble.
- Everything else (capture, counters, FSM, output registers) lives in `countdown_display`.

## Test plan
- Reset, input 00:00, run 10×SCAN_DIV cycles → `alarm` = 0, `an` cycles 1110→1101→1011→0111, `seg` = 7'h3F (0) each slot.
- Input 12:34 → after 3 edges state is ARMED. Slots show 4 = 7'h66, 3 = 7'h4F, 2 = 7'h5B, 1 = 7'h06. `dp` = 1 only with `an` = 1011.
- Step input 00:01 → 00:00 → `alarm` rises 4 edges later and stays high exactly ALARM_CYCLES cycles. Display toggles blank every BLINK_DIV cycles; then IDLE shows steady 0000.
- During EXPIRED, load 05:00 → `alarm` falls, steady display resumes, `dp` returns.
- Toggle input between 12:34 and 56:78 every cycle → `stable` never changes, state stays put. Then force second = 8'hA0 → tens digit shows 7'h40 (dash).
- With `COUNTDOWN_DISPLAY_BLANK_LEADING_ZERO_EN`, input 05:00 → `seg` = 0 when `an` = 0111. Without the macro → `seg` = 7'h3F in that slot.
